// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core and aux masters for the data-memory bus.
// One registered transaction at a time: IDLE -> ACCESS -> [WAIT] -> RESP.
module dmem_arbiter #(
   parameter int unsigned READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic [31:0] c_rdata,
   output logic        c_ack,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic [31:0] a_rdata,
   output logic        a_ack,
   output logic        dmem_we,
   output logic        dmem_re,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   localparam logic [1:0] LAT_M1 =
      2'((READ_LAT == 0) ? 0 : READ_LAT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] c_rdata_q, c_rdata_d;
   logic [31:0] a_rdata_q, a_rdata_d;
   logic        grant_aux;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         c_rdata_q <= '0;
         a_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         c_rdata_q <= c_rdata_d;
         a_rdata_q <= a_rdata_d;
      end
   end

   // On a tie the master that did not own the last grant wins.
   assign grant_aux = a_req & (~c_req | ~owner_q);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      c_rdata_d = c_rdata_q;
      a_rdata_d = a_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (c_req | a_req) begin
               owner_d = grant_aux;
               we_d    = grant_aux ? a_we    : c_we;
               addr_d  = grant_aux ? a_addr  : c_addr;
               wdata_d = grant_aux ? a_wdata : c_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d = RESP;
            end else if (READ_LAT == 0) begin
               if (owner_q) a_rdata_d = dmem_rdata;
               else         c_rdata_d = dmem_rdata;
               state_d = RESP;
            end else begin
               cnt_d   = LAT_M1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               if (owner_q) a_rdata_d = dmem_rdata;
               else         c_rdata_d = dmem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dmem_we    = (state_q == ACCESS) & we_q;
   assign dmem_re    = (state_q == ACCESS) & ~we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign c_ack      = (state_q == RESP) & ~owner_q;
   assign a_ack      = (state_q == RESP) & owner_q;
   assign c_rdata    = c_rdata_q;
   assign a_rdata    = a_rdata_q;
   assign busy       = (state_q != IDLE);
   assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instances at READ_LAT 0, 1 and 3, each on its
// own RAM/GP10 model whose read data is only valid in the latency cycle.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        c_req[3], c_we[3], a_req[3], a_we[3];
   logic [31:0] c_addr[3], c_wdata[3], a_addr[3], a_wdata[3];
   logic [31:0] c_rdata[3], a_rdata[3];
   logic        c_ack[3], a_ack[3];
   logic        dmem_we[3], dmem_re[3], busy[3], owner[3];
   logic [31:0] dmem_addr[3], dmem_wdata[3], dmem_rdata[3];

   function automatic int lat(int i);
      return (i == 0) ? 0 : (i == 1) ? 1 : 3;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
      dmem_arbiter #(.READ_LAT(L)) u_dut (
         .clk(clk), .rst(rst),
         .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]),
         .c_wdata(c_wdata[g]), .c_rdata(c_rdata[g]), .c_ack(c_ack[g]),
         .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]),
         .a_wdata(a_wdata[g]), .a_rdata(a_rdata[g]), .a_ack(a_ack[g]),
         .dmem_we(dmem_we[g]), .dmem_re(dmem_re[g]),
         .dmem_addr(dmem_addr[g]), .dmem_wdata(dmem_wdata[g]),
         .dmem_rdata(dmem_rdata[g]), .busy(busy[g]), .owner(owner[g])
      );
   end

   // Memory model: RAM words 0..1023, GP10 at byte 0x1000 reads 0xA5.
   logic [31:0] ram[3][1024];
   int          vcnt[3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            vcnt[i] <= 0;
            for (int j = 0; j < 1024; j++) ram[i][j] <= '0;
         end else begin
            if (dmem_we[i] && dmem_addr[i][31:12] == 20'd0)
               ram[i][dmem_addr[i][11:2]] <= dmem_wdata[i];
            if (dmem_re[i])
               vcnt[i] <= 1;
            else if (vcnt[i] != 0 && vcnt[i] < lat(i))
               vcnt[i] <= vcnt[i] + 1;
            else
               vcnt[i] <= 0;
         end
      end
   end

   function automatic logic [31:0] rd(int i);
      bit ok;
      ok = (lat(i) == 0) ? dmem_re[i] : (vcnt[i] == lat(i));
      if (!ok) return 32'hBAD0BAD0;
      if (dmem_addr[i][31:12] == 20'd0) return ram[i][dmem_addr[i][11:2]];
      if (dmem_addr[i][31:2] == 30'h400) return 32'h000000A5;
      return 32'h0;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) dmem_rdata[i] = rd(i);
   end

   int n_chk = 0;
   int n_bad = 0;
   logic [31:0] exp_cr[3], exp_ar[3];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(int d, bit aux, bit req, bit we,
                        logic [31:0] addr, logic [31:0] wd);
      if (aux) begin
         a_req[d] = req; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
      end else begin
         c_req[d] = req; c_we[d] = we; c_addr[d] = addr; c_wdata[d] = wd;
      end
   endtask

   typedef struct {
      int          d;
      bit          aux;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack;
   } vec_t;

   vec_t tbl[$];

   task automatic run_txn(input vec_t v, input int k);
      int str = 0;
      bit done = 0;
      bit oth = 0;
      int d = v.d;
      chk($sformatf("v%0d idle", k), busy[d], 0);
      drive(d, v.aux, 1'b1, v.we, v.addr, v.wdata);
      for (int n = 1; n <= 8 && !done; n++) begin
         @(negedge clk);
         if (dmem_we[d] || dmem_re[d]) begin
            str++;
            chk($sformatf("v%0d strobe_cyc", k), n, 1);
            chk($sformatf("v%0d dmem_we", k), dmem_we[d], v.we);
            chk($sformatf("v%0d dmem_addr", k), dmem_addr[d], v.addr);
            if (v.we) chk($sformatf("v%0d dmem_wdata", k), dmem_wdata[d], v.wdata);
         end
         oth |= v.aux ? c_ack[d] : a_ack[d];
         if (v.aux ? a_ack[d] : c_ack[d]) begin
            done = 1;
            chk($sformatf("v%0d ack_cyc", k), n, v.ack);
            chk($sformatf("v%0d strobes", k), str, 1);
         end
      end
      drive(d, v.aux, 1'b0, v.we, v.addr, v.wdata);
      chk($sformatf("v%0d ack_seen", k), done, 1);
      chk($sformatf("v%0d other_ack", k), oth, 0);
      if (!v.we) begin
         if (v.aux) exp_ar[d] = v.rdata;
         else       exp_cr[d] = v.rdata;
      end
      chk($sformatf("v%0d c_rdata", k), c_rdata[d], exp_cr[d]);
      chk($sformatf("v%0d a_rdata", k), a_rdata[d], exp_ar[d]);
      @(negedge clk);
      chk($sformatf("v%0d ack_pulse", k), v.aux ? a_ack[d] : c_ack[d], 0);
      chk($sformatf("v%0d back_idle", k), busy[d], 0);
   endtask

   task automatic mid_seq(int d, bit drop, logic [31:0] addr, logic [31:0] data);
      int acks = 0;
      int ackc = 0;
      int extra = 0;
      drive(d, 1'b1, 1'b1, 1'b0, addr, 32'h0);
      @(negedge clk);
      chk($sformatf("mid%0d re", d), dmem_re[d], 1);
      @(negedge clk);
      if (drop) begin
         a_req[d] = 1'b0;
      end else begin
         a_addr[d] = 32'h1000; a_wdata[d] = '1; a_we[d] = 1'b1;
      end
      for (int n = 3; n <= 8; n++) begin
         @(negedge clk);
         if (dmem_we[d] || dmem_re[d]) extra++;
         if (n == 3) chk($sformatf("mid%0d addr_hold", d), dmem_addr[d], addr);
         if (a_ack[d]) begin
            acks++;
            ackc = n;
            chk($sformatf("mid%0d a_rdata", d), a_rdata[d], data);
            a_req[d] = 1'b0;
            a_we[d]  = 1'b0;
         end
      end
      a_req[d] = 1'b0;
      a_we[d]  = 1'b0;
      chk($sformatf("mid%0d acks", d), acks, 1);
      chk($sformatf("mid%0d ack_cyc", d), ackc, 2 + lat(d));
      chk($sformatf("mid%0d extra_strobe", d), extra, 0);
      exp_ar[d] = data;
   endtask

   localparam int NMAIN = 13;

   initial begin
      int got;
      int ord[4];
      int quiet;

      tbl.push_back('{1, 0, 1, 'h10,   'hDEADBEEF, 'h0,        2});
      tbl.push_back('{1, 0, 0, 'h10,   'h0,        'hDEADBEEF, 3});
      tbl.push_back('{1, 1, 1, 'h20,   'h12345678, 'h0,        2});
      tbl.push_back('{1, 1, 0, 'h20,   'h0,        'h12345678, 3});
      tbl.push_back('{1, 0, 0, 'h20,   'h0,        'h12345678, 3});
      tbl.push_back('{1, 0, 0, 'h1000, 'h0,        'hA5,       3});
      tbl.push_back('{1, 1, 0, 'h4000, 'h0,        'h0,        3});
      tbl.push_back('{0, 0, 1, 'h30,   'hCAFEF00D, 'h0,        2});
      tbl.push_back('{0, 0, 0, 'h30,   'h0,        'hCAFEF00D, 2});
      tbl.push_back('{0, 1, 0, 'h1000, 'h0,        'hA5,       2});
      tbl.push_back('{2, 1, 1, 'h40,   'h55AA55AA, 'h0,        2});
      tbl.push_back('{2, 1, 0, 'h40,   'h0,        'h55AA55AA, 5});
      tbl.push_back('{2, 0, 0, 'h1000, 'h0,        'hA5,       5});
      tbl.push_back('{2, 0, 1, 'h44,   'h0BADF00D, 'h0,        2});
      tbl.push_back('{2, 0, 0, 'h44,   'h0,        'h0BADF00D, 5});

      for (int i = 0; i < 3; i++) begin
         drive(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         drive(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         exp_cr[i] = '0;
         exp_ar[i] = '0;
      end
      for (int k = 0; k < 4; k++) ord[k] = 2;

      // Reset with both masters requesting GP10 reads on the READ_LAT=1 unit.
      rst = 1'b1;
      drive(1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst busy", busy[1], 0);
      chk("rst dmem_re", dmem_re[1], 0);
      chk("rst dmem_we", dmem_we[1], 0);
      chk("rst c_ack", c_ack[1], 0);
      chk("rst a_ack", a_ack[1], 0);
      chk("rst dmem_addr", dmem_addr[1], 0);
      chk("rst dmem_wdata", dmem_wdata[1], 0);
      chk("rst c_rdata", c_rdata[1], 0);
      chk("rst a_rdata", a_rdata[1], 0);
      chk("rst owner", owner[1], 1);
      rst = 1'b0;
      @(negedge clk);
      chk("first dmem_re", dmem_re[1], 1);
      chk("first owner", owner[1], 0);
      chk("first dmem_addr", dmem_addr[1], 32'h1000);

      got = 0;
      for (int n = 0; n < 40 && got < 4; n++) begin
         @(negedge clk);
         if (c_ack[1]) begin
            ord[got] = 0;
            got++;
            exp_cr[1] = 32'hA5;
            chk("cont c_rdata", c_rdata[1], exp_cr[1]);
            chk("cont a_rdata kept", a_rdata[1], exp_ar[1]);
         end
         if (a_ack[1]) begin
            ord[got] = 1;
            got++;
            exp_ar[1] = 32'hA5;
            chk("cont a_rdata", a_rdata[1], exp_ar[1]);
            chk("cont c_rdata kept", c_rdata[1], exp_cr[1]);
         end
         if (got == 4) begin
            c_req[1] = 1'b0;
            a_req[1] = 1'b0;
         end
      end
      c_req[1] = 1'b0;
      a_req[1] = 1'b0;
      chk("cont grants", got, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("cont order%0d", k), ord[k], k % 2);
      @(negedge clk);
      chk("cont idle", busy[1], 0);

      for (int k = 0; k < NMAIN; k++) run_txn(tbl[k], k);

      mid_seq(2, 1'b0, 32'h40, 32'h55AA55AA);
      mid_seq(1, 1'b1, 32'h20, 32'h12345678);

      // Reset while the READ_LAT=3 unit sits in WAIT.
      drive(2, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
      repeat (3) @(negedge clk);
      chk("rstw in_wait", busy[2], 1);
      chk("rstw no_strobe_yet", dmem_re[2], 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      c_req[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_cr[i] = '0;
         exp_ar[i] = '0;
      end
      chk("rstw c_ack", c_ack[2], 0);
      chk("rstw busy", busy[2], 0);
      chk("rstw owner", owner[2], 1);
      chk("rstw c_rdata", c_rdata[2], 0);
      quiet = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (c_ack[2] || a_ack[2] || dmem_re[2] || dmem_we[2] || busy[2]) quiet++;
      end
      chk("rstw quiet", quiet, 0);

      for (int k = NMAIN; k < tbl.size(); k++) run_txn(tbl[k], k);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the shared data-memory bus. It sits between two masters and the core-side port of the data-memory decoder (RAM words 0..1023, GP10 at word 1024): the CPU data port (`c_*`) and an auxiliary master such as a program loader or DMA (`a_*`). It grants one transaction at a time with round-robin fairness, drives exactly one single-cycle read or write strobe per transaction, waits the memory read latency, and returns data with a one-cycle acknowledge.

## Interface
- `READ_LAT`, default 1: cycles from the read strobe to valid `dmem_rdata`. Legal range 0..3.

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `c_req` in 1: core request. Held high until `c_ack`.
- `c_we` in 1: core operation, 1 = write, 0 = read.
- `c_addr` in 32: core byte address.
- `c_wdata` in 32: core write data.
- `c_rdata` out 32: core read data. Valid in the `c_ack` cycle; held until the next core read ack.
- `c_ack` out 1: core transaction complete, one-cycle pulse.
- `a_req`, `a_we`, `a_addr`, `a_wdata`, `a_rdata`, `a_ack`: the same set for the auxiliary master.
- `dmem_we` out 1: write strobe to the decoder.
- `dmem_re` out 1: read strobe to the decoder.
- `dmem_addr` out 32: byte address to the decoder.
- `dmem_wdata` out 32: write data to the decoder.
- `dmem_rdata` in 32: read data from the decoder.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 1: current or last grantee, 0 = core, 1 = aux.

## Operation
- **States:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - Sample `c_req` and `a_req`.
  - If only one is high, grant it.
  - If both are high, grant the requester that is not `owner` (round-robin).
  - On a grant, latch the grantee's `we`, `addr` and `wdata` into internal registers, update `owner`, and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS (exactly 1 cycle):**
  - Drive `dmem_addr` and `dmem_wdata` from the latched registers.
  - Assert `dmem_we` if the latched `we` is 1; otherwise assert `dmem_re`.
  - Write: go to RESP.
  - Read with `READ_LAT` = 0: capture `dmem_rdata` into the grantee's rdata register and go to RESP.
  - Read with `READ_LAT` > 0: load the wait counter with `READ_LAT` − 1 and go to WAIT.
- **WAIT:**
  - Strobes are low; `dmem_addr` still holds the latched address.
  - When the counter is 0, capture `dmem_rdata` into the grantee's rdata register and go to RESP. Otherwise decrement the counter.
- **RESP (exactly 1 cycle):**
  - Pulse the grantee's ack; the other ack stays 0.
  - Go to IDLE unconditionally.
  - The grantee's `req` is ignored in this cycle, so a master that keeps `req` high re-arbitrates in the following IDLE cycle.
- **Request handling:**
  - Request fields are latched at grant; changes on `*_addr`, `*_we` and `*_wdata` after the grant do not affect the transaction in flight.
  - A master that drops `req` before its ack still completes the latched transaction and still receives the ack.
  - The non-granted master's request stays pending and is not lost.
- **Bus defaults:** outside ACCESS, `dmem_we` and `dmem_re` are 0 and `dmem_wdata` holds the latched value.
- **rdata registers:** written only on that master's read completion. Writes leave them unchanged.
- **Address handling:** the arbiter does no address decoding. Unmapped addresses return whatever `dmem_rdata` supplies (0 from the decoder) and complete normally.

## Timing
- **Reset values:**
  - State IDLE.
  - `dmem_we`, `dmem_re`, `c_ack`, `a_ack`, `busy` all 0.
  - `dmem_addr`, `dmem_wdata`, `c_rdata`, `a_rdata` all 0.
  - `owner` = 1, so the core wins the first tie.
  - Wait counter 0.
- **Reset mid-transaction:** the transaction is aborted. No strobe and no ack occur in the cycle after `rst`, and all values return to reset state.
- **Latency from the cycle `req` is sampled in IDLE (cycle 0):**
  - Strobe in cycle 1.
  - Write ack in cycle 2.
  - Read ack in cycle 2 + `READ_LAT`.
- **Throughput:** one transaction per 3 + `READ_LAT` cycles for reads and 3 cycles for writes (IDLE, ACCESS, RESP).
- **Simultaneous requests:** if both masters hold `req` continuously, grants strictly alternate.
- **Single request:** a lone requester is granted on every IDLE cycle regardless of `owner`.
- **Fixed properties:**
  - Only one of `dmem_we` and `dmem_re` is ever high, and only in ACCESS.
  - There is exactly one strobe per ack.
  - Outputs are registered or decoded from state only; there is no combinational path from `*_req` to `dmem_*`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both `req` high → all outputs 0 and `owner` = 1 during reset; after release the core is granted first and `dmem_re` rises 1 cycle after the first IDLE cycle.
- **Core write then read, `READ_LAT` = 1:**
  - Stimulus: core writes `c_addr` = 0x10, `c_wdata` = 0xDEADBEEF, then reads 0x10 against a RAM model.
  - Write: `dmem_we` for 1 cycle with `dmem_addr` = 0x10; `c_ack` 1 cycle later.
  - Read: `dmem_re` pulse; `c_ack` 2 cycles after the strobe with `c_rdata` = 0xDEADBEEF.
- **Contention:** both masters hold `req` with reads to 0x1000 (GP10, `gp10_datar` = 0x00A5) for 4 transactions → grant order core, aux, core, aux; each `rdata` = 0x000000A5; `a_rdata` is unchanged by the core reads.
- **Latency sweep:** `READ_LAT` = 0 and 3 → read ack at cycle 2 and cycle 5 after the request is sampled, with the correct data captured.
- **Mid-transaction changes:** change `a_addr`, and separately drop `a_req`, during WAIT → `dmem_addr` keeps the latched value and `a_ack` still pulses once.
- **Reset in WAIT:** assert `rst` in WAIT → no ack, state IDLE, and the next transaction runs normally.
